// File: rtl/j1_io_pkg.sv
// Shared definitions for the J1 I/O bus bridge: FSM encoding, error-flag
// bit positions and the internal status page.
package j1_io_pkg;

    localparam int SLOT_W = 3;

    localparam logic [7:0] STATUS_PAGE = 8'hFF;

    localparam int FLAG_MISS  = 0;
    localparam int FLAG_TO    = 1;
    localparam int FLAG_PROTO = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/j1_io_decode.sv
// Page decoder: compares the CPU page against every slot page and returns
// the lowest matching slot index plus a hit flag.
module j1_io_decode
    import j1_io_pkg::*;
#(
    parameter int                  NSLOTS     = 4,
    parameter logic [NSLOTS*8-1:0] SLOT_PAGES = {8'h71, 8'h70, 8'h69, 8'h67}
) (
    input  logic [7:0]        i_page,
    output logic              o_hit,
    output logic [SLOT_W-1:0] o_slot
);

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        o_hit  = 1'b0;
        o_slot = '0;
        for (int i = NSLOTS - 1; i >= 0; i--) begin
            if (SLOT_PAGES[8*i +: 8] == i_page) begin
                o_hit  = 1'b1;
                o_slot = SLOT_W'(i);
            end
        end
    end

endmodule

// File: rtl/j1_io_bus.sv
// J1 CPU to peripheral-slot bridge. One transfer at a time; the CPU is
// stalled from the request cycle until the DONE cycle.
// Optional build macro J1_IO_BUS_STATUS_EN maps page 8'hFF to an internal
// status register (read flags / write-one-to-clear flags).
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for rd/wr; request fields latched when one arrives
// ACCESS | slot selected, waiting for its ready or the wait limit
// DONE   | one cycle, stall released, read data valid on j1_io_din
module j1_io_bus
    import j1_io_pkg::*;
#(
    parameter int                  NSLOTS     = 4,
    parameter logic [NSLOTS*8-1:0] SLOT_PAGES = {8'h71, 8'h70, 8'h69, 8'h67},
    parameter int                  TIMEOUT    = 15,
    parameter logic [15:0]         MISS_DATA  = 16'h0666,
    parameter logic [15:0]         TO_DATA    = 16'hDEAD
) (
    input  logic                   sys_clk_i,
    input  logic                   sys_rst_i,
    input  logic                   j1_io_rd,
    input  logic                   j1_io_wr,
    input  logic [15:0]            j1_io_addr,
    input  logic [15:0]            j1_io_dout,
    output logic [15:0]            j1_io_din,
    output logic                   j1_stall,
    output logic [NSLOTS-1:0]      per_cs,
    output logic                   per_rd,
    output logic                   per_wr,
    output logic [7:0]             per_addr,
    output logic [15:0]            per_wdata,
    input  logic [NSLOTS*16-1:0]   per_rdata,
    input  logic [NSLOTS-1:0]      per_ready,
    output logic [2:0]             err_flags
);

    state_t              r_state;
    logic [SLOT_W-1:0]   r_slot;
    logic                r_wr;
    logic [7:0]          r_cnt;
    logic [2:0]          r_flags;
    logic [NSLOTS-1:0]   r_cs;
    logic                r_rd_o;
    logic                r_wr_o;
    logic [7:0]          r_addr;
    logic [15:0]         r_wdata;
    logic [15:0]         r_din;

    logic                w_req;
    logic                w_wr;
    logic                w_proto;
    logic                w_hit;
    logic                w_status;
    logic [SLOT_W-1:0]   w_slot;
    logic [NSLOTS-1:0]   w_cs_hot;
    logic                w_ready;
    logic [15:0]         w_rdata;
    logic [7:0]          w_cnt_next;
    logic                w_expired;
    logic [2:0]          w_set;
    logic [2:0]          w_clr;

    assign w_req   = j1_io_rd | j1_io_wr;
    assign w_wr    = j1_io_wr;
    assign w_proto = j1_io_rd & j1_io_wr;

    j1_io_decode #(
        .NSLOTS     (NSLOTS),
        .SLOT_PAGES (SLOT_PAGES)
    ) u_decode (
        .i_page (j1_io_addr[15:8]),
        .o_hit  (w_hit),
        .o_slot (w_slot)
    );

`ifdef J1_IO_BUS_STATUS_EN
    assign w_status = (j1_io_addr[15:8] == STATUS_PAGE);
`else
    assign w_status = 1'b0;
`endif

    // One-hot select for the incoming slot, and ready/rdata of the latched slot.
    always_comb begin
        w_cs_hot = '0;
        w_ready  = 1'b0;
        w_rdata  = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            if (w_slot == SLOT_W'(i)) w_cs_hot[i] = 1'b1;
            if (r_slot == SLOT_W'(i)) begin
                w_ready = per_ready[i];
                w_rdata = per_rdata[16*i +: 16];
            end
        end
    end

    // Flag updates for a request accepted in IDLE; the status page has
    // priority over the slot map and is never a miss.
    always_comb begin
        w_set             = '0;
        w_set[FLAG_PROTO] = w_proto;
        w_set[FLAG_MISS]  = ~w_status & ~w_hit;
        w_clr             = (w_status & w_wr) ? j1_io_dout[2:0] : 3'b000;
    end

    // Abort once the ACCESS cycle being completed is the TIMEOUT-th one.
    assign w_cnt_next = r_cnt + 8'd1;
    assign w_expired  = (w_cnt_next == 8'(TIMEOUT));

    assign j1_stall  = (r_state == ST_ACCESS) | ((r_state == ST_IDLE) & w_req);
    assign j1_io_din = r_din;
    assign per_cs    = r_cs;
    assign per_rd    = r_rd_o;
    assign per_wr    = r_wr_o;
    assign per_addr  = r_addr;
    assign per_wdata = r_wdata;
    assign err_flags = r_flags;

    // Transfer FSM with registered peripheral strobes and read-data capture.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_state <= ST_IDLE;
            r_slot  <= '0;
            r_wr    <= 1'b0;
            r_cnt   <= '0;
            r_flags <= '0;
            r_cs    <= '0;
            r_rd_o  <= 1'b0;
            r_wr_o  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_din   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_addr  <= j1_io_addr[7:0];
                        r_wdata <= j1_io_dout;
                        r_wr    <= w_wr;
                        r_slot  <= w_slot;
                        r_flags <= (r_flags & ~w_clr) | w_set;
                        if (w_status) begin
                            r_state <= ST_DONE;
                            if (!w_wr) r_din <= {13'b0, r_flags};
                        end else if (w_hit) begin
                            r_state <= ST_ACCESS;
                            r_cnt   <= '0;
                            r_cs    <= w_cs_hot;
                            r_rd_o  <= ~w_wr;
                            r_wr_o  <= w_wr;
                        end else begin
                            r_state <= ST_DONE;
                            if (!w_wr) r_din <= MISS_DATA;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_cnt <= w_cnt_next;
                    if (w_ready || w_expired) begin
                        r_state <= ST_DONE;
                        r_cs    <= '0;
                        r_rd_o  <= 1'b0;
                        r_wr_o  <= 1'b0;
                        if (w_ready) begin
                            if (!r_wr) r_din <= w_rdata;
                        end else begin
                            r_flags[FLAG_TO] <= 1'b1;
                            if (!r_wr) r_din <= TO_DATA;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_j1_io_bus.sv
module tb_j1_io_bus;

    localparam int NS = 4;
    localparam int TO = 15;
`ifdef J1_IO_BUS_STATUS_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          rd, wr;
    logic [15:0]   addr, dout;
    logic [15:0]   din;
    logic          stall;
    logic [NS-1:0] cs;
    logic          prd, pwr;
    logic [7:0]    paddr;
    logic [15:0]   pwdata;
    logic [NS*16-1:0] prdata;
    logic [NS-1:0] pready;
    logic [2:0]    flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    j1_io_bus dut (
        .sys_clk_i  (clk),
        .sys_rst_i  (rst),
        .j1_io_rd   (rd),
        .j1_io_wr   (wr),
        .j1_io_addr (addr),
        .j1_io_dout (dout),
        .j1_io_din  (din),
        .j1_stall   (stall),
        .per_cs     (cs),
        .per_rd     (prd),
        .per_wr     (pwr),
        .per_addr   (paddr),
        .per_wdata  (pwdata),
        .per_rdata  (prdata),
        .per_ready  (pready),
        .err_flags  (flags)
    );

    typedef struct {
        logic          rd, wr;
        logic [15:0]   addr, dout;
        int            delay;
        int            tslot;
        logic [15:0]   rdata;
        logic [15:0]   e_din;
        logic [NS-1:0] e_cs;
        int            e_acc;
        logic [2:0]    e_flags;
    } vec_t;

    int            obs_acc, obs_stall;
    logic [NS-1:0] obs_cs;
    logic          obs_rd, obs_wr, obs_unstable;
    logic [7:0]    obs_addr;
    logic [15:0]   obs_wdata, obs_din;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; rd = 1'b0; wr = 1'b0; pready = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Issues one CPU request, holds the strobes while stalled, and raises
    // ready on tslot in ACCESS cycle 'delay' (other slots get random ready).
    task automatic run_txn(input logic r, input logic w, input logic [15:0] a,
                           input logic [15:0] d, input int delay, input int tslot);
        logic [NS-1:0] noise;
        int   acc;
        logic done;
        @(negedge clk);
        rd = r; wr = w; addr = a; dout = d;
        pready = NS'($urandom);
        acc = 0; done = 1'b0;
        obs_stall = 0; obs_cs = '0; obs_rd = 1'b0; obs_wr = 1'b0;
        obs_unstable = 1'b0; obs_addr = '0; obs_wdata = '0; obs_din = '0;
        for (int c = 0; c < 300 && !done; c++) begin
            #1;
            if (!stall) begin
                obs_din = din;
                done = 1'b1;
            end else begin
                obs_stall++;
                if (cs != '0) begin
                    if (acc == 0) begin
                        obs_cs = cs; obs_rd = prd; obs_wr = pwr;
                        obs_addr = paddr; obs_wdata = pwdata;
                    end else if (cs != obs_cs || prd != obs_rd || pwr != obs_wr) begin
                        obs_unstable = 1'b1;
                    end
                    noise = NS'($urandom);
                    if (tslot >= 0) noise[tslot] = (acc == delay);
                    pready = noise;
                    acc++;
                end
                @(negedge clk);
            end
        end
        rd = 1'b0; wr = 1'b0; pready = '0;
        obs_acc = acc;
        if (!done) begin
            checks++; errors++;
            $display("FAIL txn_bound: stall never released for addr %h", a);
        end
    endtask

    task automatic check_txn(input string tag, input logic isw, input logic [15:0] a,
                             input logic [15:0] d, input logic [15:0] e_din,
                             input logic [NS-1:0] e_cs, input int e_acc, input logic [2:0] e_flags);
        chk({tag, "_din"},   {16'h0, obs_din}, {16'h0, e_din});
        chk({tag, "_cs"},    {28'h0, obs_cs}, {28'h0, e_cs});
        chk({tag, "_acc"},   obs_acc, e_acc);
        chk({tag, "_stall"}, obs_stall, e_acc + 1);
        chk({tag, "_flags"}, {29'h0, flags}, {29'h0, e_flags});
        if (e_acc > 0) begin
            chk({tag, "_addr"},  {24'h0, obs_addr}, {24'h0, a[7:0]});
            chk({tag, "_wdata"}, {16'h0, obs_wdata}, {16'h0, d});
            chk({tag, "_dir"},   {30'h0, obs_rd, obs_wr}, {30'h0, ~isw, isw});
            chk({tag, "_stable"}, {31'h0, obs_unstable}, 32'h0);
        end
        // Read data must hold into the following idle cycle.
        @(negedge clk); #1;
        chk({tag, "_hold"}, {16'h0, din}, {16'h0, e_din});
    endtask

    vec_t vecs[8];
    logic [7:0] pages[NS] = '{8'h67, 8'h69, 8'h70, 8'h71};
    logic [7:0] pool[8]   = '{8'h67, 8'h69, 8'h70, 8'h71, 8'h50, 8'hFF, 8'h00, 8'h68};

    initial begin
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; dout = '0;
        prdata = '0; pready = '0;

        vecs[0] = '{1'b1, 1'b0, 16'h6900, 16'h0000,   0,  1, 16'h1234, 16'h1234, 4'b0010,  1, 3'b000};
        vecs[1] = '{1'b0, 1'b1, 16'h7003, 16'hA5A5,   2,  2, 16'h0000, 16'h1234, 4'b0100,  3, 3'b000};
        vecs[2] = '{1'b1, 1'b0, 16'h7100, 16'h0000,  14,  3, 16'hC0DE, 16'hC0DE, 4'b1000, 15, 3'b000};
        vecs[3] = '{1'b1, 1'b0, 16'h5000, 16'h0000,   0, -1, 16'h0000, 16'h0666, 4'b0000,  0, 3'b001};
        vecs[4] = '{1'b1, 1'b0, 16'h6712, 16'h0000, 255,  0, 16'h9999, 16'hDEAD, 4'b0001, 15, 3'b011};
        vecs[5] = '{1'b1, 1'b1, 16'h7155, 16'h0BEE,   1,  3, 16'h0000, 16'hDEAD, 4'b1000,  2, 3'b111};
        vecs[6] = '{1'b0, 1'b1, 16'h1234, 16'h7777,   0, -1, 16'h0000, 16'hDEAD, 4'b0000,  0, 3'b111};
        vecs[7] = '{1'b1, 1'b0, 16'h6944, 16'h0000,   3,  1, 16'h0F0F, 16'h0F0F, 4'b0010,  4, 3'b111};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_din",   {16'h0, din}, 32'h0);
        chk("rst_cs",    {28'h0, cs}, 32'h0);
        chk("rst_strb",  {30'h0, prd, pwr}, 32'h0);
        chk("rst_addr",  {24'h0, paddr}, 32'h0);
        chk("rst_wdata", {16'h0, pwdata}, 32'h0);
        chk("rst_flags", {29'h0, flags}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            prdata = {$urandom, $urandom};
            if (vecs[v].tslot >= 0) prdata[16*vecs[v].tslot +: 16] = vecs[v].rdata;
            run_txn(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].dout, vecs[v].delay, vecs[v].tslot);
            check_txn($sformatf("vec%0d", v), vecs[v].wr, vecs[v].addr, vecs[v].dout,
                      vecs[v].e_din, vecs[v].e_cs, vecs[v].e_acc, vecs[v].e_flags);
        end

        // Reset landing in the second ACCESS cycle aborts the transfer.
        @(negedge clk);
        rd = 1'b1; addr = 16'h6700; pready = '0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("abort_pre_cs", {28'h0, cs}, 32'h1);
        rst = 1'b1; rd = 1'b0;
        @(negedge clk); #1;
        chk("abort_cs",    {28'h0, cs}, 32'h0);
        chk("abort_strb",  {30'h0, prd, pwr}, 32'h0);
        chk("abort_flags", {29'h0, flags}, 32'h0);
        chk("abort_stall", {31'h0, stall}, 32'h0);
        rst = 1'b0;

`ifdef J1_IO_BUS_STATUS_EN
        run_txn(1'b1, 1'b0, 16'h5000, 16'h0000, 0, -1);
        check_txn("st_miss", 1'b0, 16'h5000, 16'h0000, 16'h0666, 4'b0000, 0, 3'b001);
        run_txn(1'b1, 1'b0, 16'hFF00, 16'h0000, 0, -1);
        check_txn("st_rd1", 1'b0, 16'hFF00, 16'h0000, 16'h0001, 4'b0000, 0, 3'b001);
        run_txn(1'b0, 1'b1, 16'hFF00, 16'h0001, 0, -1);
        check_txn("st_wr", 1'b1, 16'hFF00, 16'h0001, 16'h0001, 4'b0000, 0, 3'b000);
        run_txn(1'b1, 1'b0, 16'hFF00, 16'h0000, 0, -1);
        check_txn("st_rd2", 1'b0, 16'hFF00, 16'h0000, 16'h0000, 4'b0000, 0, 3'b000);
`endif

        // Randomized transfers against a page-table / rule-based model.
        do_reset();
        begin
            logic [2:0]  m_flags;
            logic [15:0] m_din;
            m_flags = '0;
            m_din   = '0;
            for (int t = 0; t < 80; t++) begin
                logic [7:0]  pg;
                logic [15:0] a, d;
                logic        r, w;
                int          kind, delay, slot, acc;
                logic [NS-1:0] ecs;
                pg = pool[$urandom_range(0, 7)];
                a  = {pg, 8'($urandom)};
                d  = 16'($urandom);
                kind = int'($urandom_range(0, 2));
                r = (kind != 1);
                w = (kind != 0);
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4: delay = int'($urandom_range(0, 3));
                    5, 6, 7:       delay = int'($urandom_range(4, 20));
                    default:       delay = 255;
                endcase
                prdata = {$urandom, $urandom};
                slot = -1;
                for (int i = NS - 1; i >= 0; i--) if (pages[i] == pg) slot = i;
                acc = 0;
                ecs = '0;
                if (STAT && pg == 8'hFF) begin
                    slot = -1;
                    if (w) m_flags = m_flags & ~d[2:0];
                    else   m_din = {13'b0, m_flags};
                end else if (slot < 0) begin
                    m_flags[0] = 1'b1;
                    if (!w) m_din = 16'h0666;
                end else begin
                    ecs[slot] = 1'b1;
                    if (delay + 1 <= TO) begin
                        acc = delay + 1;
                        if (!w) m_din = prdata[16*slot +: 16];
                    end else begin
                        acc = TO;
                        m_flags[1] = 1'b1;
                        if (!w) m_din = 16'hDEAD;
                    end
                end
                if (r && w) m_flags[2] = 1'b1;
                run_txn(r, w, a, d, delay, slot);
                check_txn($sformatf("rnd%0d", t), w, a, d, m_din, ecs, acc, m_flags);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
